// File: rtl/joybus_poll_sequencer.sv
// Controller-side Joybus pin owner: arbitrates the shared line between the RX poll
// detector and the TX response serializer, and snapshots the pad state for each reply.
module joybus_poll_sequencer #(
  parameter int                 SNAP_W      = 32,
  parameter int                 GAP_CYC     = 50,
  parameter int                 GAP_MAX_CYC = 500,
  parameter int                 TX_TO_CYC   = 4000,
  parameter logic [SNAP_W-1:0]  NEUTRAL     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              console_did_poll,
  input  logic              line_high,
  input  logic [SNAP_W-1:0] pad_state,
  input  logic              pad_valid,
  input  logic              tx_done,
  output logic              rx_enable,
  output logic              reset_poll_status,
  output logic              tx_start,
  output logic [SNAP_W-1:0] tx_data,
  output logic [15:0]       poll_cnt,
  output logic              err_abort,
  output logic [2:0]        fsm_state
);

  // Handshakes: pad_valid, tx_done, tx_start and reset_poll_status are single-cycle
  // strobes with no back-pressure; tx_data is stable from tx_start until tx_done.

  typedef enum logic [2:0] {
    S_LISTEN  = 3'd0,
    S_GAP     = 3'd1,
    S_LOAD    = 3'd2,
    S_START   = 3'd3,
    S_SEND    = 3'd4,
    S_RELEASE = 3'd5,
    S_ABORT   = 3'd6,
    S_DRAIN   = 3'd7
  } state_t;

  localparam int TMO_MAX = (GAP_MAX_CYC > TX_TO_CYC) ? GAP_MAX_CYC : TX_TO_CYC;
  localparam int TMO_W   = $clog2(TMO_MAX + 1);
  localparam int GAP_W   = $clog2(GAP_CYC + 1);

  localparam logic [GAP_W-1:0] GAP_LAST     = GAP_W'(GAP_CYC - 1);
  localparam logic [TMO_W-1:0] GAP_TMO_LAST = TMO_W'(GAP_MAX_CYC - 1);
  localparam logic [TMO_W-1:0] TX_TMO_LAST  = TMO_W'(TX_TO_CYC - 1);

  state_t            state, state_nx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo;
  logic [SNAP_W-1:0] shadow;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_LISTEN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_LISTEN:  if (console_did_poll) state_nx = S_GAP;
      // A completed gap wins over a timeout landing on the same cycle.
      S_GAP: begin
        if (line_high && gap_cnt == GAP_LAST) state_nx = S_LOAD;
        else if (tmo == GAP_TMO_LAST)         state_nx = S_ABORT;
      end
      S_LOAD:    state_nx = S_START;
      S_START:   state_nx = S_SEND;
      S_SEND: begin
        if (tx_done)                  state_nx = S_RELEASE;
        else if (tmo == TX_TMO_LAST)  state_nx = S_ABORT;
      end
      S_RELEASE: state_nx = S_DRAIN;
      S_ABORT:   state_nx = S_DRAIN;
      S_DRAIN:   if (!console_did_poll && line_high) state_nx = S_LISTEN;
      default:   state_nx = S_LISTEN;
    endcase
  end

  always_comb begin
    rx_enable         = (state == S_LISTEN);
    tx_start          = (state == S_START);
    reset_poll_status = (state == S_RELEASE) || (state == S_ABORT);
    fsm_state         = state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= NEUTRAL;
      tx_data   <= '0;
      poll_cnt  <= '0;
      err_abort <= 1'b0;
      gap_cnt   <= '0;
      tmo       <= '0;
    end else begin
      if (pad_valid) shadow <= pad_state;
      case (state)
        S_LISTEN: begin
          gap_cnt <= '0;
          tmo     <= '0;
        end
        S_GAP: begin
          gap_cnt <= line_high ? gap_cnt + GAP_W'(1) : '0;
          tmo     <= tmo + TMO_W'(1);
        end
        // A strobe arriving in the snapshot cycle is fresher than the shadow copy.
        S_LOAD:    tx_data   <= pad_valid ? pad_state : shadow;
        S_START:   tmo       <= '0;
        S_SEND:    tmo       <= tmo + TMO_W'(1);
        S_RELEASE: poll_cnt  <= poll_cnt + 16'd1;
        S_ABORT:   err_abort <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_joybus_poll_sequencer.sv
// Bench for joybus_poll_sequencer: each poll is scheduled from a transaction-level model
// (gap run-length scan, timeout arithmetic, last-strobe-wins shadow) and compared to the DUT.
module tb_joybus_poll_sequencer;

  localparam int          SNAP_W      = 32;
  localparam int          GAP_CYC     = 50;
  localparam int          GAP_MAX_CYC = 500;
  localparam int          TX_TO_CYC   = 4000;
  localparam logic [31:0] NEUTRAL     = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        console_did_poll;
  logic        line_high;
  logic [31:0] pad_state;
  logic        pad_valid;
  logic        tx_done;
  logic        rx_enable;
  logic        reset_poll_status;
  logic        tx_start;
  logic [31:0] tx_data;
  logic [15:0] poll_cnt;
  logic        err_abort;
  logic [2:0]  fsm_state;

  joybus_poll_sequencer #(
    .SNAP_W(SNAP_W), .GAP_CYC(GAP_CYC), .GAP_MAX_CYC(GAP_MAX_CYC),
    .TX_TO_CYC(TX_TO_CYC), .NEUTRAL(NEUTRAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .console_did_poll(console_did_poll),
    .line_high(line_high), .pad_state(pad_state), .pad_valid(pad_valid),
    .tx_done(tx_done), .rx_enable(rx_enable), .reset_poll_status(reset_poll_status),
    .tx_start(tx_start), .tx_data(tx_data), .poll_cnt(poll_cnt),
    .err_abort(err_abort), .fsm_state(fsm_state)
  );

  // 25 MHz
  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard and reference-model state
  logic [31:0] exp_q[$];
  logic [31:0] m_shadow;
  logic [31:0] m_tx;
  int          m_polls;
  bit          m_err;
  int          last_start_n;

  // Per-poll scenario knobs
  bit          pat[GAP_MAX_CYC];
  int          pad_gap_n;
  logic [31:0] pad_gap_val;
  bit          load_strobe;
  logic [31:0] load_val;
  bit          send_strobe;
  logic [31:0] send_val;
  int          done_d;
  bit          spurious;
  int          drain_k;
  bit          rst_mid;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: all high, 1: low for len cycles from p, 2: stuck low, 3: sparse random lows
  task automatic set_pattern(input int mode, input int p, input int len);
    for (int i = 0; i < GAP_MAX_CYC; i++) begin
      case (mode)
        1:       pat[i] = !(i >= p && i < p + len);
        2:       pat[i] = 1'b0;
        3:       pat[i] = ($urandom_range(0, 39) != 0);
        default: pat[i] = 1'b1;
      endcase
    end
  endtask

  task automatic defaults();
    set_pattern(0, 0, 0);
    pad_gap_n   = 0;
    pad_gap_val = 32'h0;
    load_strobe = 1'b0;
    load_val    = 32'h0;
    send_strobe = 1'b0;
    send_val    = 32'h0;
    done_d      = 5;
    spurious    = 1'b0;
    drain_k     = 0;
    rst_mid     = 1'b0;
  endtask

  task automatic pad_strobe(input logic [31:0] val);
    pad_valid = 1'b1;
    pad_state = val;
    step();
    pad_valid = 1'b0;
    m_shadow  = val;
  endtask

  task automatic run_poll(input string name);
    int          run, last_i, exp_start, exp_rps, exp_listen, end_n;
    int          start_n, rps_n, n_starts, n_rps, rx_busy;
    bit          gap_abort, tx_abort;
    logic [31:0] s, exp_data;

    // The gap completes at the first index where the line has been high GAP_CYC times in a row.
    run = 0;
    last_i = GAP_MAX_CYC - 1;
    gap_abort = 1'b1;
    for (int i = 0; i < GAP_MAX_CYC; i++) begin
      run = pat[i] ? run + 1 : 0;
      if (run == GAP_CYC) begin
        last_i = i;
        gap_abort = 1'b0;
        break;
      end
    end
    if (pad_gap_n > last_i + 1) pad_gap_n = last_i + 1;

    s = m_shadow;
    if (pad_gap_n != 0) s = pad_gap_val;
    if (!gap_abort && load_strobe) s = load_val;
    exp_data = s;
    if (!gap_abort && send_strobe) s = send_val;

    tx_abort   = !gap_abort && (done_d == 0);
    exp_start  = gap_abort ? -1 : last_i + 2;
    exp_rps    = gap_abort ? last_i + 1
               : (tx_abort ? exp_start + TX_TO_CYC + 1 : exp_start + done_d);
    exp_listen = exp_rps + 1 + ((drain_k > 1) ? drain_k : 1);
    end_n      = rst_mid ? exp_start + 3 : exp_listen;
    if (!gap_abort) begin
      exp_q.push_back(exp_data);
      m_tx = exp_data;
    end

    rst_n = 1'b1;
    pad_valid = 1'b0;
    tx_done = 1'b0;
    console_did_poll = 1'b1;
    line_high = 1'b1;
    step();

    start_n = -1; rps_n = -1; n_starts = 0; n_rps = 0; rx_busy = 0;
    for (int n = 1; n <= end_n; n++) begin
      console_did_poll = (n <= exp_rps);
      if (n - 1 <= last_i) line_high = pat[n-1];
      else line_high = !(n > exp_rps && n <= exp_rps + drain_k);
      pad_valid = 1'b0;
      pad_state = $urandom;
      if (n == pad_gap_n) begin pad_valid = 1'b1; pad_state = pad_gap_val; end
      if (!gap_abort && load_strobe && n == last_i + 2) begin pad_valid = 1'b1; pad_state = load_val; end
      if (!gap_abort && send_strobe && n == exp_start + 2) begin pad_valid = 1'b1; pad_state = send_val; end
      tx_done = !gap_abort && ((done_d != 0 && n == exp_start + done_d) || (spurious && n == exp_start + 1));
      rst_n = !(rst_mid && n == end_n);
      step();
      if (rst_mid && n == end_n) break;
      if (tx_start) begin
        n_starts++;
        if (start_n < 0) start_n = n;
        if (exp_q.size() > 0) check_eq({name, "_tx_data_at_start"}, tx_data, exp_q.pop_front());
      end
      if (reset_poll_status) begin
        n_rps++;
        if (rps_n < 0) rps_n = n;
      end
      if (n < exp_listen && rx_enable) rx_busy++;
      if (n == exp_rps) check_eq({name, "_tx_data_held"}, tx_data, m_tx);
    end
    last_start_n = start_n;
    pad_valid = 1'b0;
    tx_done = 1'b0;
    console_did_poll = 1'b0;
    line_high = 1'b1;

    if (rst_mid) begin
      check_eq({name, "_rst_rx_enable"}, rx_enable, 1);
      check_eq({name, "_rst_tx_start"}, tx_start, 0);
      check_eq({name, "_rst_reset_poll_status"}, reset_poll_status, 0);
      check_eq({name, "_rst_tx_data"}, tx_data, 0);
      check_eq({name, "_rst_poll_cnt"}, poll_cnt, 0);
      check_eq({name, "_rst_err_abort"}, err_abort, 0);
      rst_n = 1'b1;
      m_shadow = NEUTRAL; m_tx = 32'h0; m_polls = 0; m_err = 1'b0;
      exp_q.delete();
      step();
    end else begin
      m_shadow = s;
      if (gap_abort || tx_abort) m_err = 1'b1;
      else m_polls++;
      check_eq({name, "_start_cycle"}, start_n, exp_start);
      check_eq({name, "_start_count"}, n_starts, gap_abort ? 0 : 1);
      check_eq({name, "_release_cycle"}, rps_n, exp_rps);
      check_eq({name, "_release_count"}, n_rps, 1);
      check_eq({name, "_rx_busy_cycles"}, rx_busy, 0);
      check_eq({name, "_rx_rearmed"}, rx_enable, 1);
      check_eq({name, "_poll_cnt"}, poll_cnt, m_polls % 65536);
      check_eq({name, "_err_abort"}, err_abort, m_err);
      check_eq({name, "_queue_empty"}, exp_q.size(), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; console_did_poll = 1'b0; line_high = 1'b1;
    pad_state = 32'h0; pad_valid = 1'b0; tx_done = 1'b0;
    m_shadow = NEUTRAL; m_tx = 32'h0; m_polls = 0; m_err = 1'b0; last_start_n = -1;
    step(); step();
    check_eq("reset_rx_enable", rx_enable, 1);
    check_eq("reset_tx_start", tx_start, 0);
    check_eq("reset_reset_poll_status", reset_poll_status, 0);
    check_eq("reset_tx_data", tx_data, 0);
    check_eq("reset_poll_cnt", poll_cnt, 0);
    check_eq("reset_err_abort", err_abort, 0);
    rst_n = 1'b1;
    step();

    defaults();
    run_poll("neutral");

    defaults();
    pad_strobe(32'h1234_5678);
    run_poll("basic");
    check_eq("basic_latency_from_flag", last_start_n + 1, GAP_CYC + 2);

    defaults();
    load_strobe = 1'b1; load_val = 32'hA5A5_0001;
    run_poll("load_bypass");

    defaults();
    set_pattern(1, 30, 1);
    run_poll("gap_restart");

    defaults();
    set_pattern(2, 0, 0);
    run_poll("gap_abort");

    defaults();
    done_d = 0; spurious = 1'b1;
    run_poll("tx_abort");

    defaults();
    done_d = TX_TO_CYC + 1;
    run_poll("tx_done_last_cycle");

    for (int k = 0; k < 14; k++) begin
      defaults();
      set_pattern($urandom_range(0, 3), $urandom_range(0, 100), $urandom_range(1, 20));
      if ($urandom_range(0, 1) == 1) begin
        pad_gap_n = $urandom_range(1, 120);
        pad_gap_val = $urandom;
      end
      load_strobe = ($urandom_range(0, 2) == 0); load_val = $urandom;
      send_strobe = ($urandom_range(0, 1) == 1); send_val = $urandom;
      done_d = $urandom_range(2, 30);
      spurious = ($urandom_range(0, 1) == 1);
      drain_k = $urandom_range(0, 5);
      run_poll($sformatf("rand%0d", k));
    end

    defaults();
    pad_strobe(32'hDEAD_BEEF);
    done_d = 0; rst_mid = 1'b1;
    run_poll("reset_in_send");

    defaults();
    run_poll("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
